multi_clkdiv: RTL and testbench
===============================

// Module: multi_clkdiv
// PURPOSE
//  N-channel programmable clock divider / tick generator. It is the successor to the fixed single-channel divider.
//  Each channel has a run-time divisor, a per-channel enable and a toggle or pulse mode.
//  Divisor updates are glitch-free: a new value is held in a shadow register until the current period ends.
//  Feeds display-scan, debounce and counter-rate logic from one system clock; a global sync input phase-aligns all channels.
// PARAMETERS
//  N_CH         4      number of independent channels (1..16)
//  DIV_W        16     divisor/counter width in bits
//  DEFAULT_DIV  49999  divisor loaded into every channel at reset (terminal count value D)
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst        in   1              reset, synchronous, active-high
//  en         in   N_CH           per-channel enable
//  mode       in   N_CH           per-channel mode: 0 = TOGGLE (square wave), 1 = PULSE (1-cycle strobe)
//  sync       in   1              1-cycle strobe: restart all channels in phase
//  cfg_we     in   1              divisor write strobe
//  cfg_ch     in   clog2(N_CH)    target channel of the write (min width 1)
//  cfg_div    in   DIV_W          new terminal count D
//  clk_out    out  N_CH           divided output: TOGGLE = square wave, PULSE = copy of tick
//  tick       out  N_CH           1-cycle strobe at each period end, in both modes
//  pend       out  N_CH           1 = a shadow divisor is waiting to be applied
// BEHAVIOUR
//  Per-channel state: cnt[DIV_W], div_act[DIV_W], div_shd[DIV_W], pend, tog.
//  Reset (rst=1 at posedge):
//   - cnt=0; div_act=div_shd=DEFAULT_DIV; pend=0; tog=0.
//   - Outputs clk_out=0, tick=0, pend=0 from the next cycle.
//  Priority per channel, per cycle: rst > sync > !en > terminal count > count.
//  Counting (en=1): cnt runs 0..D, where D=div_act.
//   - On the cycle cnt==D: cnt<=0; tick<=1 (registered, high for exactly 1 cycle); tog<=~tog.
//   - Otherwise cnt<=cnt+1 and tick<=0.
//  Resulting periods:
//   - tick period = D+1 clocks.
//   - TOGGLE clk_out = tog: period 2(D+1), 50% duty.
//   - PULSE clk_out = tick.
//   - First tick comes D+1 clocks after the first cycle en is sampled high.
//  D=0: tick held high every cycle; TOGGLE output = clk/2. This is legal and not an error.
//  Disabled (en=0): cnt<=0, tog<=0, tick<=0, so clk_out=0. div_act, div_shd and pend are retained.
//  Divisor write (cfg_we=1, cfg_ch<N_CH):
//   - Channel disabled: div_act<=cfg_div immediately; pend stays 0.
//   - Channel enabled: div_shd<=cfg_div; pend<=1.
//   - At the next terminal count, div_act<=div_shd and pend<=0, in the same cycle cnt wraps.
//   - The new period uses the new value, so no period is truncated or runt.
//   - A second write while pend=1 overwrites div_shd; only the last value is applied.
//   - A write on the same cycle as the terminal count goes to shadow and is applied at the following terminal count.
//  cfg_ch >= N_CH: the write is ignored; no state changes.
//  sync=1, every channel:
//   - cnt<=0; tog<=0; tick<=0.
//   - Any pending shadow is applied (div_act<=div_shd, pend<=0).
//   - sync wins over a same-cycle terminal count (no tick that cycle).
//   - A same-cycle cfg_we to the enabled target channel still lands in shadow with pend=1.
//  Mode change while enabled takes effect on the next cycle; the counter is not disturbed.
//  rst mid-period discards any pending shadow value.
//  Arithmetic: unsigned, DIV_W bits; cnt never exceeds div_act (the comparison is ==, and loads happen only at wrap).
// STRUCTURE
//  Shared package clkdiv_pkg:
//   - MODE_TOGGLE=1'b0, MODE_PULSE=1'b1.
//   - clog2 function (replaces the local log helper).
//   - Default DIV_W and DEFAULT_DIV constants.
//  Sub-module clkdiv_chan: one channel holding cnt, div_act/div_shd/pend, tog and tick.
//   - Inputs: en, mode, sync, wr (decoded cfg_we & cfg_ch==i), cfg_div.
//  Top: generate loop of N_CH clkdiv_chan instances, plus the cfg_ch decode.
// TESTING
//  1 rst, then en[0]=1, D=DEFAULT_DIV=49999 -> first tick at 50000 clocks; clk_out[0] toggles every 50000.
//  2 ch1 disabled, write D=3, then en[1]=1, TOGGLE -> tick every 4 clocks; clk_out[1] 4 high / 4 low.
//  3 ch1 running D=3, write D=9 at cnt=1:
//     - pend[1]=1 until the wrap; the remaining period is still 4 clocks.
//     - Next tick spacing is 10 clocks; pend returns to 0 at the wrap.
//  4 ch2 D=0, PULSE -> tick and clk_out held high continuously; TOGGLE -> clk/2.
//  5 ch0 D=4 and ch3 D=6 running, sync pulse -> both restart at cnt=0 with clk_out=0.
//     - Ticks coincide again after 35 clocks (LCM 5,7).
//  6 rst asserted mid-period with pend=1 -> next cycle: all outputs 0, pend=0, div_act=49999.
//     - Write with cfg_ch=N_CH -> no state change.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the multi-channel clock divider
package clkdiv_pkg;
    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE = 1'b1;
    localparam int DIV_W_DEF = 16;
    localparam int DEFAULT_DIV_DEF = 49999;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) if ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with shadowed divisor, toggle/pulse output
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);
    logic [DIV_W-1:0] cnt, div_act, div_shd, cnt_n, act_n, shd_n;
    logic pend_n, tog, tog_n, tick_n;
    // next state: sync > disabled > terminal count > count, then the divisor write lands on top
    always_comb begin
        cnt_n = cnt + 1'b1;
        act_n = div_act;
        shd_n = div_shd;
        pend_n = pend;
        tog_n = tog;
        tick_n = 1'b0;
        if (sync) begin
            cnt_n = '0;
            tog_n = 1'b0;
            act_n = pend ? div_shd : div_act;
            pend_n = 1'b0;
        end else if (!en) begin
            cnt_n = '0;
            tog_n = 1'b0;
        end else if (cnt == div_act) begin
            cnt_n = '0;
            tick_n = 1'b1;
            tog_n = ~tog;
            act_n = pend ? div_shd : div_act;
            pend_n = 1'b0;
        end
        if (wr && en) begin
            shd_n = cfg_div;
            pend_n = 1'b1;
        end else if (wr) begin
            act_n = cfg_div;
        end
    end
    // state and registered outputs; clk_out follows the mode sampled at this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            div_act <= DIV_W'(DEFAULT_DIV);
            div_shd <= DIV_W'(DEFAULT_DIV);
            pend <= 1'b0;
            tog <= 1'b0;
            tick <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt <= cnt_n;
            div_act <= act_n;
            div_shd <= shd_n;
            pend <= pend_n;
            tog <= tog_n;
            tick <= tick_n;
            clk_out <= (mode == MODE_PULSE) ? tick_n : tog_n;
        end
    end
endmodule

// File: rtl/multi_clkdiv.sv
// multi_clkdiv: N-channel programmable clock divider / tick generator
module multi_clkdiv
    import clkdiv_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DIV_W = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  mode,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pend
);
    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            clkdiv_chan #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
                .clk(clk),
                .rst(rst),
                .en(en[i]),
                .mode(mode[i]),
                .sync(sync),
                .wr(cfg_we && (cfg_ch == CH_W'(i))),
                .cfg_div(cfg_div),
                .clk_out(clk_out[i]),
                .tick(tick[i]),
                .pend(pend[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_multi_clkdiv.sv
// tb_multi_clkdiv: scoreboard bench for multi_clkdiv against a per-cycle reference model
module tb_multi_clkdiv;
    localparam int N = 5;
    localparam int W = 16;
    localparam int DEF = 49999;
    logic clk = 0, rst = 1, sync = 0, cfg_we = 0;
    logic [N-1:0] en = '0, mode = '0;
    logic [2:0] cfg_ch = '0;
    logic [W-1:0] cfg_div = '0;
    logic [N-1:0] clk_out, tick, pend;
    multi_clkdiv #(.N_CH(N), .DIV_W(W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sync(sync), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick), .pend(pend)
    );
    always #5 clk = ~clk;
    typedef struct packed {logic [N-1:0] c; logic [N-1:0] t; logic [N-1:0] p;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;
    int m_elapsed[N], m_period[N], m_next_period[N];
    bit m_pend[N], m_tog[N], m_tick[N];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
        end
    endtask
    // reference: each channel counts elapsed clocks in its period of (D+1) clocks
    task automatic cyc();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            bit wr;
            wr = cfg_we && (int'(cfg_ch) == i);
            if (rst) begin
                m_elapsed[i] = 0; m_period[i] = DEF + 1; m_next_period[i] = DEF + 1;
                m_pend[i] = 0; m_tog[i] = 0; m_tick[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (sync || !en[i]) begin
                    m_elapsed[i] = 0;
                    m_tog[i] = 0;
                    if (sync && m_pend[i]) m_period[i] = m_next_period[i];
                    if (sync) m_pend[i] = 0;
                end else begin
                    m_elapsed[i]++;
                    if (m_elapsed[i] == m_period[i]) begin
                        m_elapsed[i] = 0;
                        m_tick[i] = 1;
                        m_tog[i] = !m_tog[i];
                        if (m_pend[i]) m_period[i] = m_next_period[i];
                        m_pend[i] = 0;
                    end
                end
                if (wr && en[i]) begin
                    m_next_period[i] = int'(cfg_div) + 1;
                    m_pend[i] = 1;
                end else if (wr) m_period[i] = int'(cfg_div) + 1;
            end
            e.c[i] = rst ? 1'b0 : (mode[i] ? m_tick[i] : m_tog[i]);
            e.t[i] = m_tick[i];
            e.p[i] = m_pend[i];
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input int ch, input int d);
        cfg_we = 1; cfg_ch = 3'(ch); cfg_div = W'(d);
        cyc();
        cfg_we = 0;
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                @(negedge clk);
                e = q.pop_front();
                chk("clk_out", 32'(clk_out), 32'(e.c));
                chk("tick", 32'(tick), 32'(e.t));
                chk("pend", 32'(pend), 32'(e.p));
            end
        end
    end
    initial begin
        repeat (3) cyc();
        rst = 0;
        en[0] = 1;
        repeat (50010) cyc();
        wr(1, 3);
        en[1] = 1;
        repeat (24) cyc();
        for (int k = 0; k < 8 && m_elapsed[1] != 1; k++) cyc();
        wr(1, 9);
        repeat (40) cyc();
        wr(2, 0);
        en[2] = 1; mode[2] = 1;
        repeat (10) cyc();
        mode[2] = 0;
        repeat (10) cyc();
        en[2] = 0;
        wr(0, 4);
        wr(3, 6);
        en[3] = 1;
        repeat (7) cyc();
        sync = 1;
        cyc();
        sync = 0;
        repeat (40) cyc();
        repeat (4000) begin
            if ($urandom_range(0, 15) == 0) en = N'($urandom);
            if ($urandom_range(0, 15) == 0) mode = N'($urandom);
            sync = ($urandom_range(0, 63) == 0);
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_ch = 3'($urandom_range(0, 7));
            cfg_div = W'($urandom_range(0, 12));
            cyc();
        end
        sync = 0; cfg_we = 0;
        en = 5'b00001;
        wr(0, 7);
        wr(0, 11);
        rst = 1;
        cyc();
        rst = 0; en = '0;
        cyc();
        cfg_we = 1; cfg_ch = 3'(N); cfg_div = 16'd3;
        cyc();
        cfg_we = 0;
        repeat (3) cyc();
        @(negedge clk);
        #1;
        chk("div_act_after_rst", 32'(dut.g_ch[0].u_ch.div_act), DEF);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
